// File: rtl/riscv_pkg.sv
// Shared definitions for the small RISC-V pipeline slice.
// Holds the default datapath widths, the reset fetch address, the major
// opcode constants used by decode, and the instruction-fetch state encoding.
package riscv_pkg;

  localparam int          INSTRSIZE = 32;
  localparam int          ADDRSIZE  = 64;
  localparam logic [63:0] RESET_PC  = 64'h0;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] RT  = 7'b0110011;  // register-register ALU
  localparam logic [6:0] IT  = 7'b0010011;  // register-immediate ALU
  localparam logic [6:0] LW  = 7'b0000011;  // load word
  localparam logic [6:0] SW  = 7'b0100011;  // store word
  localparam logic [6:0] BEQ = 7'b1100011;  // branch

  // Fetch FSM: issue a request, wait for its response, hold the result for decode.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Fetches one instruction at a time from instruction memory (at most one
// request outstanding), holds it for decode, and advances the PC by 4.
// A branch redirect may arrive in any state: it reloads the PC (word aligned)
// and any instruction in flight or held is discarded.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, stays high with its payload stable until
// that edge, unless a redirect or reset cancels the transfer.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       fetch request to instruction memory
//   imem_resp_valid/data            fetch response (no back-pressure)
//   redirect_valid/redirect_pc      branch-taken redirect
//   out_valid/ready                 handshake towards decode
//   out_instruction/out_pc          held instruction and its address
// The FSM state is the internal signal "state" (type fetch_state_e).
module instruction_fetch #(
  parameter int                      INSTRSIZE = riscv_pkg::INSTRSIZE,
  parameter int                      ADDRSIZE  = riscv_pkg::ADDRSIZE,
  parameter logic [ADDRSIZE-1:0]     RESET_PC  = ADDRSIZE'(riscv_pkg::RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDRSIZE-1:0]  imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [INSTRSIZE-1:0] imem_resp_data,
  input  logic                 redirect_valid,
  input  logic [ADDRSIZE-1:0]  redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTRSIZE-1:0] out_instruction,
  output logic [ADDRSIZE-1:0]  out_pc
);

  import riscv_pkg::*;

  fetch_state_e          state, state_next;
  logic [ADDRSIZE-1:0]   pc, pc_next;
  logic                  drop, drop_next;
  logic                  out_valid_next;
  logic [INSTRSIZE-1:0]  out_instruction_next;
  logic [ADDRSIZE-1:0]   out_pc_next;
  logic [ADDRSIZE-1:0]   redirect_target;

  // Instructions are word aligned: the two low bits of the target are cleared.
  assign redirect_target = redirect_pc & ~{{(ADDRSIZE-2){1'b0}}, 2'b11};

  always_comb begin
    state_next           = state;
    pc_next              = pc;
    drop_next            = drop;
    out_valid_next       = out_valid;
    out_instruction_next = out_instruction;
    out_pc_next          = out_pc;
    imem_req_valid       = 1'b0;
    imem_req_addr        = pc;

    unique case (state)
      FETCH_REQ: begin
        // No request is presented while reset is held.
        imem_req_valid = rst_n;
        if (imem_req_ready) begin
          state_next = FETCH_WAIT;
          // The accepted request targets the old PC; its response is stale.
          if (redirect_valid) drop_next = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (redirect_valid) begin
          if (imem_resp_valid) begin
            // The outstanding response is here and stale: discard it now,
            // otherwise nothing would ever arrive to clear the drop flag.
            drop_next  = 1'b0;
            state_next = FETCH_REQ;
          end else begin
            drop_next = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop) begin
            drop_next  = 1'b0;
            state_next = FETCH_REQ;
          end else begin
            out_valid_next       = 1'b1;
            out_instruction_next = imem_resp_data;
            out_pc_next          = pc;
            pc_next              = pc + ADDRSIZE'(4);
            state_next           = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_REQ;
      end
    endcase

    // Redirect overrides the PC in every state and cancels any held result.
    if (redirect_valid) begin
      pc_next        = redirect_target;
      out_valid_next = 1'b0;
      if (state == FETCH_HOLD) state_next = FETCH_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= FETCH_REQ;
      pc              <= RESET_PC;
      drop            <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
    end else begin
      state           <= state_next;
      pc              <= pc_next;
      drop            <= drop_next;
      out_valid       <= out_valid_next;
      out_instruction <= out_instruction_next;
      out_pc          <= out_pc_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch.
// A behavioural memory answers each accepted request after a random latency
// with a word derived from its address. The reference model is the
// architectural instruction stream: starting at RESET_PC (or at a redirect
// target with the low bits cleared) decode must see consecutive words at
// addresses +4 apart. The expected next delivery sits in exp_q; a monitor
// pops and compares on every decode handshake.
module tb_instruction_fetch;

  localparam int          IW       = 32;
  localparam int          AW       = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic          clk;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instruction;
  logic [AW-1:0] out_pc;

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / scoreboard ----------------
  int checks     = 0;
  int passed     = 0;
  int deliveries = 0;
  logic [95:0] exp_q[$];  // {pc, instruction}

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_restart(input logic [63:0] pc);
    exp_q.delete();
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // ---------------- stimulus knobs and memory state ----------------
  int   p_ready = 100, p_outr = 100, p_redir = 0, p_spur = 0;
  int   min_lat = 0, max_lat = 0;
  logic rst_knob = 1'b0;

  bit          outstanding = 0;
  int          lat = 0;
  logic [63:0] pend_addr = '0;
  bit          late = 0;
  logic [63:0] late_addr = '0;

  function automatic logic [63:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return {$urandom(), $urandom()};
      1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      2:       return 64'($urandom_range(0, 255));
      default: return 64'h1000 + 64'($urandom_range(0, 63));
    endcase
  endfunction

  // One clock cycle: sample at negedge, update models at posedge, drive at +1.
  task automatic step();
    bit          acc;
    logic [63:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (acc) check("single_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk);
    if (!rst_n) begin
      if (outstanding) begin
        late      = 1;
        late_addr = pend_addr;
      end
      outstanding = 0;
      model_restart(RESET_PC);
    end else begin
      if (redirect_valid) model_restart(redirect_pc & ~64'd3);
      if (acc) begin
        outstanding = 1;
        lat         = $urandom_range(min_lat, max_lat);
        pend_addr   = a;
      end
    end
    #1;
    rst_n           = rst_knob;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom();
    if (late && rst_knob) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(late_addr);
      late            = 0;
    end else if (outstanding && rst_knob) begin
      if (lat == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        outstanding     = 0;
      end else begin
        lat--;
      end
    end else if ($urandom_range(0, 99) < p_spur) begin
      imem_resp_valid = 1'b1;  // stray response while nothing is outstanding
    end
    imem_req_ready = $urandom_range(0, 99) < p_ready;
    out_ready      = $urandom_range(0, 99) < p_outr;
    redirect_valid = $urandom_range(0, 99) < p_redir;
    redirect_pc    = rand_target();
  endtask

  // ---------------- monitor ----------------
  logic        hold_prev = 0, req_prev = 0;
  logic [63:0] prev_pc, prev_addr;
  logic [31:0] prev_instr;
  logic [95:0] e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        deliveries++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: got delivery pc %0h with no expectation", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", out_pc, e[95:32]);
          check("deliver_instr", 64'(out_instruction), 64'(e[31:0]));
          exp_q.push_back({e[95:32] + 64'd4, mem_word(e[95:32] + 64'd4)});
        end
      end
      if (out_valid) check("no_req_in_hold", 64'(imem_req_valid), 64'd0);
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_pc_stable", out_pc, prev_pc);
        check("hold_instr_stable", 64'(out_instruction), 64'(prev_instr));
      end
      if (req_prev) begin
        check("req_valid_stable", 64'(imem_req_valid), 64'd1);
        check("req_addr_stable", imem_req_addr, prev_addr);
      end
      hold_prev  = out_valid && !out_ready && !redirect_valid;
      req_prev   = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instruction;
      prev_addr  = imem_req_addr;
    end else begin
      hold_prev = 0;
      req_prev  = 0;
    end
  end

  // ---------------- test sequence ----------------
  int d0;

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // Reset state, then straight-line fetch with an always-ready memory.
    rst_knob = 1'b0;
    repeat (3) step();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instruction), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    rst_knob = 1'b1;
    step(); #1;
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    d0 = deliveries;
    repeat (12) step();
    check("throughput_4_in_12", 64'(deliveries - d0), 64'd4);

    // Memory not ready for 3 cycles: request held at 0x0.
    rst_knob = 1'b0; repeat (2) step();
    p_ready = 0; p_outr = 0; rst_knob = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("stall_req_valid", 64'(imem_req_valid), 64'd1);
      check("stall_req_addr", imem_req_addr, 64'h0);
    end
    p_ready = 100;

    // Decode stalls 5 cycles in HOLD.
    for (int i = 0; i < 20 && !out_valid; i++) begin step(); #1; end
    check("hold_reached", 64'(out_valid), 64'd1);
    begin
      logic [63:0] hpc; logic [31:0] hin;
      hpc = out_pc; hin = out_instruction;
      check("hold_first_pc", hpc, 64'h0);
      for (int i = 0; i < 4; i++) begin
        step(); #1;
        check("hold5_pc", out_pc, hpc);
        check("hold5_instr", 64'(out_instruction), 64'(hin));
        check("hold5_no_req", 64'(imem_req_valid), 64'd0);
      end
    end
    p_outr = 100;

    // Redirect to 0x103 while waiting for a response.
    min_lat = 2; max_lat = 2;
    for (int i = 0; i < 20 && !outstanding; i++) begin step(); #1; end
    check("wait_reached", 64'(outstanding), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    step(); #1;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin step(); #1; end
    check("redir_req_addr", imem_req_addr, 64'h100);
    for (int i = 0; i < 20 && !out_valid; i++) begin step(); #1; end
    check("redir_out_pc", out_pc, 64'h100);

    // Address wrap at the top of the address space.
    min_lat = 0; max_lat = 0;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); #1;
    for (int i = 0; i < 20 && !(out_valid && out_pc == 64'hFFFF_FFFF_FFFF_FFFC); i++) begin step(); #1; end
    check("top_fetched", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); #1;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin step(); #1; end
    check("wrap_req_addr", imem_req_addr, 64'h0);

    // Reset while waiting, then a late response from the aborted request.
    min_lat = 2; max_lat = 2;
    for (int i = 0; i < 20 && !outstanding; i++) begin step(); #1; end
    check("wait_before_rst", 64'(outstanding), 64'd1);
    rst_knob = 1'b0; rst_n = 1'b0;
    step();
    rst_knob = 1'b1;
    step(); #1;
    check("late_resp_driven", 64'(imem_resp_valid), 64'd1);
    check("late_out_valid", 64'(out_valid), 64'd0);
    check("restart_req_addr", imem_req_addr, RESET_PC);
    step(); #1;
    check("late_ignored", 64'(out_valid), 64'd0);
    for (int i = 0; i < 20 && !out_valid; i++) begin step(); #1; end
    check("restart_out_pc", out_pc, RESET_PC);

    // Randomized traffic.
    p_ready = 70; p_outr = 60; p_redir = 8; p_spur = 20; min_lat = 0; max_lat = 3;
    d0 = deliveries;
    repeat (3000) step();
    check("random_progress", 64'(deliveries - d0 >= 100), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
